// File: rtl/ms_arb_pkg.sv
// Shared types and helpers for the round-robin master/slave arbiter.
// Holds the FSM encoding, command codes and the round-robin picker.
package ms_arb_pkg;

    localparam int MAX_MASTERS = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } pick_t;

    // First requester at or above ptr, wrapping at n (n need not be 2^k).
    function automatic pick_t rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input logic [2:0]             ptr,
        input int                     n
    );
        pick_t      p;
        logic [3:0] j;
        p = '0;
        for (int k = MAX_MASTERS - 1; k >= 0; k--) begin
            if (k < n) begin
                j = {1'b0, ptr} + 4'(k);
                if (j >= 4'(n)) j = j - 4'(n);
                if (req[j[2:0]]) begin
                    p.valid = 1'b1;
                    p.idx   = j[2:0];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/ms_arb_id_fifo.sv
// In-order FIFO of master IDs for outstanding reads.
// Extra pointer bit separates full from empty.
module ms_arb_id_fifo #(
    parameter int WIDTH    = 2,
    parameter int RD_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(RD_DEPTH);

    logic [WIDTH-1:0] mem [RD_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer update; a reset discards every stored ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are meaningless until pointed at.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ms_rr_arbiter.sv
// Round-robin arbiter sharing one slave port among N masters.
// Grant is held for a whole transaction; read IDs route responses back.
module ms_rr_arbiter
    import ms_arb_pkg::*;
#(
    parameter int N_MASTERS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RD_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_MASTERS-1:0]            m_req,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [N_MASTERS-1:0]            m_cmd,
    input  logic [N_MASTERS*DATA_WIDTH-1:0] m_wdata,
    output logic [N_MASTERS-1:0]            m_ack,
    output logic [DATA_WIDTH-1:0]           m_rdata,
    output logic [N_MASTERS-1:0]            m_resp,
    output logic                            s_req,
    output logic [ADDR_WIDTH-1:0]           s_addr,
    output logic                            s_cmd,
    output logic [DATA_WIDTH-1:0]           s_wdata,
    input  logic                            s_ack,
    input  logic [DATA_WIDTH-1:0]           s_rdata,
    input  logic                            s_resp,
    output logic                            err_resp
);

    localparam int OW = $clog2(N_MASTERS);

    state_e        state_q;
    state_e        state_d;
    logic [OW-1:0] owner_q;
    logic [OW-1:0] owner_d;
    logic [OW-1:0] rr_ptr_q;
    logic [OW-1:0] rr_ptr_d;
    logic [OW-1:0] owner_inc;
    logic [OW-1:0] head;
    pick_t         pick;
    logic          own_req;
    logic          own_cmd;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          read_block;
    logic          accept;

    assign pick      = rr_pick(8'(m_req), 3'(rr_ptr_q), N_MASTERS);
    assign own_req   = m_req[owner_q];
    assign own_cmd   = m_cmd[owner_q];
    assign owner_inc = (owner_q == OW'(N_MASTERS - 1)) ? '0
                                                       : owner_q + 1'b1;

    // A pop in this cycle frees a slot, so it lifts a full-FIFO stall.
    assign pop        = s_resp & ~fifo_empty;
    assign read_block = (own_cmd == CMD_READ) & fifo_full & ~pop;
    assign accept     = (state_q == GRANT) & s_req & s_ack;
    assign push       = accept & (own_cmd == CMD_READ);

    ms_arb_id_fifo #(
        .WIDTH    (OW),
        .RD_DEPTH (RD_DEPTH)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (owner_q),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Arbitrate in IDLE; leave GRANT on accept or a dropped request.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick.valid) begin
                    state_d = GRANT;
                    owner_d = OW'(pick.idx);
                end
            end
            GRANT: begin
                if (accept) begin
                    state_d  = IDLE;
                    rr_ptr_d = owner_inc;
                end else if (!own_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slave-side request path, steered by the current owner.
    always_comb begin
        s_req   = 1'b0;
        s_addr  = '0;
        s_cmd   = 1'b0;
        s_wdata = '0;
        m_ack   = '0;
        if (state_q == GRANT) begin
            s_req   = own_req & ~read_block;
            s_addr  = m_addr[int'(owner_q)*ADDR_WIDTH +: ADDR_WIDTH];
            s_cmd   = own_cmd;
            s_wdata = m_wdata[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
            m_ack[owner_q] = s_ack & s_req;
        end
    end

    // Response routing to the FIFO head, or an error when none is due.
    always_comb begin
        m_resp   = '0;
        m_rdata  = '0;
        err_resp = s_resp & fifo_empty;
        if (pop) begin
            m_resp[head] = 1'b1;
            m_rdata      = s_rdata;
        end
    end

endmodule

// File: tb/tb_ms_rr_arbiter.sv
// Self-checking bench for ms_rr_arbiter with a read-response scoreboard.
// Drives at negedge, samples 1 time unit later.
module tb_ms_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    typedef struct {
        logic [N-1:0]  resp;
        logic [DW-1:0] data;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [N-1:0]    m_req;
    logic [N*AW-1:0] m_addr;
    logic [N-1:0]    m_cmd;
    logic [N*DW-1:0] m_wdata;
    logic [N-1:0]    m_ack;
    logic [DW-1:0]   m_rdata;
    logic [N-1:0]    m_resp;
    logic            s_req;
    logic [AW-1:0]   s_addr;
    logic            s_cmd;
    logic [DW-1:0]   s_wdata;
    logic            s_ack;
    logic [DW-1:0]   s_rdata;
    logic            s_resp;
    logic            err_resp;

    exp_t          exp_q[$];
    logic [DW-1:0] slv_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;

    ms_rr_arbiter #(
        .N_MASTERS  (N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RD_DEPTH   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_req    (m_req),
        .m_addr   (m_addr),
        .m_cmd    (m_cmd),
        .m_wdata  (m_wdata),
        .m_ack    (m_ack),
        .m_rdata  (m_rdata),
        .m_resp   (m_resp),
        .s_req    (s_req),
        .s_addr   (s_addr),
        .s_cmd    (s_cmd),
        .s_wdata  (s_wdata),
        .s_ack    (s_ack),
        .s_rdata  (s_rdata),
        .s_resp   (s_resp),
        .err_resp (err_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    function automatic logic [N-1:0] oh(input int m);
        return N'(1 << m);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One master transaction; slave accepts as soon as s_req rises.
    task automatic issue(input int m, input logic cmd,
                         input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
        @(negedge clk);
        m_req = '0;
        m_req[m] = 1'b1;
        m_cmd[m] = cmd;
        m_addr[m*AW +: AW] = addr;
        m_wdata[m*DW +: DW] = data;
        s_ack = 1'b0;
        #1;
        chk("idle_sreq", 64'(s_req), 64'(0));
        @(negedge clk);
        s_ack = 1'b1;
        #1;
        chk("grant_ack", 64'(m_ack), 64'(oh(m)));
        chk("grant_addr", 64'(s_addr), 64'(addr));
        chk("grant_cmd", 64'(s_cmd), 64'(cmd));
        if (cmd == 1'b1) chk("grant_wdata", 64'(s_wdata), 64'(data));
        if (m_ack[m] && cmd == 1'b0) begin
            exp_q.push_back('{oh(m), data});
            slv_q.push_back(data);
        end
        @(negedge clk);
        m_req = '0;
        s_ack = 1'b0;
    endtask

    // Slave returns one response; checked against the scoreboard head.
    task automatic respond();
        exp_t e;
        @(negedge clk);
        s_resp  = 1'b1;
        s_rdata = (slv_q.size() != 0) ? slv_q.pop_front() : 32'hDEAD_BEEF;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("resp_onehot", 64'(m_resp), 64'(e.resp));
            chk("resp_rdata", 64'(m_rdata), 64'(e.data));
            chk("resp_noerr", 64'(err_resp), 64'(0));
        end else begin
            chk("unexp_err", 64'(err_resp), 64'(1));
            chk("unexp_resp", 64'(m_resp), 64'(0));
        end
        @(negedge clk);
        s_resp = 1'b0;
        #1;
        chk("err_pulse", 64'(err_resp), 64'(0));
        chk("resp_clear", 64'(m_resp), 64'(0));
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        m_req = '0;
        m_addr = '0;
        m_cmd = '0;
        m_wdata = '0;
        s_ack = 1'b0;
        s_rdata = '0;
        s_resp = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_sreq", 64'(s_req), 64'(0));
        chk("rst_mack", 64'(m_ack), 64'(0));
        chk("rst_mresp", 64'(m_resp), 64'(0));
        chk("rst_err", 64'(err_resp), 64'(0));
        chk("rst_saddr", 64'(s_addr), 64'(0));
        chk("rst_rdata", 64'(m_rdata), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Single write from master 2.
        issue(2, 1'b1, 32'h10, 32'hA5);
        chk("rr_ptr_after_m2", 64'(dut.rr_ptr_q), 64'(3));

        // Round-robin with all masters requesting, slave always ready.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            m_cmd[i] = 1'b1;
            m_addr[i*AW +: AW] = 32'(i * 4);
        end
        m_req = '1;
        s_ack = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (k % 2 == 1) begin
                chk("rr_ack", 64'(m_ack), 64'(oh(((k - 1) / 2) % N)));
                chk("rr_addr", 64'(s_addr), 64'((((k - 1) / 2) % N) * 4));
            end else begin
                chk("rr_bubble", 64'(m_ack), 64'(0));
            end
            @(negedge clk);
        end
        m_req = '0;
        s_ack = 1'b0;

        // Read routing: master 1 then master 3.
        issue(1, 1'b0, 32'h100, 32'h11);
        issue(3, 1'b0, 32'h300, 32'h33);
        respond();
        respond();

        // Fill the FIFO, write still passes, fifth read stalls.
        issue(1, 1'b0, 32'h400, 32'h41);
        issue(2, 1'b0, 32'h404, 32'h42);
        issue(3, 1'b0, 32'h408, 32'h43);
        issue(1, 1'b0, 32'h40C, 32'h44);
        issue(2, 1'b1, 32'h500, 32'h77);
        @(negedge clk);
        m_req = 4'b0001;
        m_cmd[0] = 1'b0;
        m_addr[0 +: AW] = 32'h410;
        @(negedge clk);
        s_ack = 1'b1;
        #1;
        chk("full_stall_sreq", 64'(s_req), 64'(0));
        chk("full_stall_ack", 64'(m_ack), 64'(0));
        @(negedge clk);
        #1;
        chk("full_hold_sreq", 64'(s_req), 64'(0));
        @(negedge clk);
        s_resp = 1'b1;
        s_rdata = slv_q.pop_front();
        #1;
        e = exp_q.pop_front();
        chk("release_sreq", 64'(s_req), 64'(1));
        chk("release_ack", 64'(m_ack), 64'(oh(0)));
        chk("release_resp", 64'(m_resp), 64'(e.resp));
        chk("release_rdata", 64'(m_rdata), 64'(e.data));
        if (m_ack[0]) begin
            exp_q.push_back('{oh(0), 32'h45});
            slv_q.push_back(32'h45);
        end
        @(negedge clk);
        m_req = '0;
        s_ack = 1'b0;
        s_resp = 1'b0;
        repeat (4) respond();

        // Unexpected responses with nothing outstanding.
        respond();
        respond();

        // Asynchronous reset in GRANT with two reads outstanding.
        issue(0, 1'b0, 32'h600, 32'h61);
        issue(2, 1'b0, 32'h604, 32'h62);
        @(negedge clk);
        m_req = 4'b0010;
        m_cmd[1] = 1'b0;
        @(negedge clk);
        s_ack = 1'b1;
        #1;
        chk("pre_rst_sreq", 64'(s_req), 64'(1));
        chk("pre_rst_ack", 64'(m_ack), 64'(oh(1)));
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_sreq", 64'(s_req), 64'(0));
        chk("async_rst_ack", 64'(m_ack), 64'(0));
        exp_q.delete();
        slv_q.delete();
        @(negedge clk);
        rst = 1'b0;
        m_req = '0;
        s_ack = 1'b0;
        respond();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ms_rr_arbiter.md
Name: ms_rr_arbiter

Overview:
- Shares one master_slave-protocol slave port between N_MASTERS master ports in the router.
- Arbitration is round-robin with a locked grant per transaction.
- Reads are tracked in an in-order ID FIFO, so each resp/rdata is routed back to the master that issued the read.
- Sits between the router's master-side ports and a single SLAVE modport endpoint.

Parameters:
- N_MASTERS, 4, number of requesting masters (2..8).
- DATA_WIDTH, 32, wdata/rdata width.
- ADDR_WIDTH, 32, address width.
- RD_DEPTH, 4, maximum outstanding reads (power of 2, at least 2).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- m_req  in  N_MASTERS  per-master request.
- m_addr  in  N_MASTERS*ADDR_WIDTH  per-master address, packed, master i at slice i.
- m_cmd  in  N_MASTERS  per-master cmd (0 read, 1 write).
- m_wdata  in  N_MASTERS*DATA_WIDTH  per-master write data.
- m_ack  out  N_MASTERS  per-master accept strobe.
- m_rdata  out  DATA_WIDTH  read data, broadcast to all masters.
- m_resp  out  N_MASTERS  one-hot read-response strobe.
- s_req  out  1  to slave.
- s_addr  out  ADDR_WIDTH  to slave.
- s_cmd  out  1  to slave.
- s_wdata  out  DATA_WIDTH  to slave.
- s_ack  in  1  slave accept.
- s_rdata  in  DATA_WIDTH  slave read data.
- s_resp  in  1  slave read-response strobe.
- err_resp  out  1  1-cycle pulse on an unexpected s_resp.

Behaviour:
- Clocking: single clock clk. Reset rst is asynchronous and active-high. All state clears on rst assertion.
- Reset values:
  - state=IDLE, owner=0, rr_ptr=0, FIFO empty.
  - s_req=0, m_ack=0, m_resp=0, err_resp=0.
  - s_addr/s_wdata/s_cmd/m_rdata=0.
- Protocol: a master holds req/addr/cmd/wdata stable until it sees ack. Slave asserts s_resp no earlier than the cycle after the s_ack of that read; responses return in order.
- FSM states:
  - IDLE: no owner. If any m_req, select the first requester scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., N_MASTERS-1, 0, ...). Register owner, go to GRANT at the next edge (1-cycle arbitration latency). If no m_req, stay in IDLE.
  - GRANT: the slave-side outputs are combinational from the owner: s_addr=m_addr[owner], s_cmd=m_cmd[owner], s_wdata=m_wdata[owner].
    - s_req = m_req[owner] & ~read_block.
    - read_block = (m_cmd[owner]==0) & fifo_full & ~pop_this_cycle.
    - m_ack[owner] = s_ack & s_req. All other m_ack bits are 0.
  - GRANT to IDLE: on s_ack & s_req. If the command was a read, push owner into the FIFO. Set rr_ptr = (owner+1) mod N_MASTERS. Exactly one idle bubble follows each accepted transaction.
  - GRANT with m_req[owner] dropped before ack (protocol violation): return to IDLE with rr_ptr unchanged.
- Response path:
  - On s_resp with FIFO non-empty: m_resp = onehot(fifo_head), m_rdata = s_rdata (combinational, same cycle), then pop.
  - On s_resp with FIFO empty: m_resp=0 and err_resp=1 for that cycle; nothing is popped.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - FIFO full: a read owner is stalled (s_req=0) until a pop frees a slot.
  - A pop in the same cycle as the stall releases it combinationally.
  - Writes are never blocked by FIFO state.
- Widths/arithmetic:
  - owner and rr_ptr are $clog2(N_MASTERS) bits. Wrap is explicit for non-power-of-2 N_MASTERS.
  - FIFO pointers are $clog2(RD_DEPTH) bits with an extra count bit to distinguish full from empty.
- Reset mid-operation: outstanding read IDs are discarded. After reset, a late s_resp raises err_resp only.

Decomposition:
- Package ms_arb_pkg:
  - state_e {IDLE, GRANT}.
  - CMD_READ=1'b0, CMD_WRITE=1'b1.
  - Function rr_pick(req vector, ptr) returning index and valid.
- Sub-module ms_arb_id_fifo: a synchronous FIFO of master IDs.
  - Parameters: width and RD_DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Reset: asynchronous, active-high on rst.

Test Plan:
- Reset then a single write: m_req[2]=1, cmd=1, addr=0x10, wdata=0xA5 -> s_req=1 one cycle later with s_addr=0x10 and s_wdata=0xA5; with s_ack=1 the same cycle, m_ack[2]=1 and rr_ptr becomes 3.
- Round-robin: all four m_req held high, slave acks immediately -> grant order 0,1,2,3,0, each transaction separated by exactly one IDLE cycle.
- Read routing: master 1 reads, then master 3 reads, slave responds in order with rdata 0x11 then 0x33 -> m_resp=0b0010 with m_rdata=0x11, then m_resp=0b1000 with m_rdata=0x33.
- FIFO full with RD_DEPTH=4: four reads accepted with no resp, and a fifth read from master 0 -> s_req stays 0. Pulse s_resp once -> the fifth read's s_req rises in the same cycle, and its ack pushes the ID.
- Unexpected response: s_resp=1 with FIFO empty -> err_resp=1 for one cycle, m_resp=0, FIFO count stays 0.
- Reset mid-operation: rst asserted asynchronously while in GRANT with 2 reads outstanding -> s_req and m_ack drop immediately; FIFO empty after release; the next s_resp gives err_resp=1.
